// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, beat payload and unload FSM states for the FFT result reader.
// The beat carries a magnitude field only when FFT_RESULT_MAG_EN is defined.
package fft_pkg;
    localparam int N = 16;
    localparam int LEVEL = $clog2(N);
    localparam int DW = 16;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic [LEVEL-1:0] index;
        logic             last;
`ifdef FFT_RESULT_MAG_EN
        logic [2*DW:0]    mag;
`endif
    } beat_t;
endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: synchronous show-ahead FIFO; a push is visible at the head the next cycle.
module fft_out_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          full, wr, rd;

    assign valid = cnt != '0;
    assign full  = cnt == CW'(DEPTH);
    assign wr    = push && !full;
    assign rd    = pop && valid;
    assign dout  = mem[rp];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= inc(wp);
            if (rd) rp <= inc(rp);
            cnt <= cnt + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;

    // the reader's credit counter must make this unreachable
    always_ff @(posedge clk)
        if (!rst && !flush) assert (!(push && full));
endmodule

// File: rtl/fft_result_reader.sv
// fft_result_reader: unloads N FFT results from the result BRAM bank as a valid/ready stream in bin order.
// FFT_RESULT_MAG_EN adds m_mag = re^2 + im^2 behind one extra pipeline stage.
module fft_result_reader
    import fft_pkg::state_e, fft_pkg::beat_t, fft_pkg::IDLE, fft_pkg::READ, fft_pkg::DRAIN, fft_pkg::DONE;
#(
    parameter int N = 16,
    parameter int LEVEL = $clog2(N),
    parameter int DW = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_start,
    input  logic             fft_done,
    input  logic             res_bank,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [LEVEL-1:0] rd_addr,
    input  logic [DW-1:0]    rd_re,
    input  logic [DW-1:0]    rd_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_re,
    output logic [DW-1:0]    m_im,
    output logic [LEVEL-1:0] m_index,
    output logic             m_last,
`ifdef FFT_RESULT_MAG_EN
    output logic [2*DW:0]    m_mag,
`endif
    output logic             unload_busy,
    output logic             unload_done
);
`ifdef FFT_RESULT_MAG_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif
    localparam int DEPTH = RD_LAT + 2 + XS;
    localparam int CW = $clog2(DEPTH + 1);

    state_e           state;
    logic             done_q, arm, pop, push, f_valid, kill;
    logic [LEVEL-1:0] addr;
    logic [CW-1:0]    outst;
    logic [RD_LAT-1:0] vp;
    logic [LEVEL-1:0] ip [RD_LAT];
    beat_t            rb, pb, head;

    assign kill        = rst || fft_start;
    assign arm         = fft_done && !done_q;
    assign rd_en       = state == READ && outst < CW'(DEPTH);
    assign rd_addr     = addr;
    assign pop         = m_valid && m_ready;
    assign unload_busy = state == READ || state == DRAIN;
    assign unload_done = state == DONE;

    // edge detector keeps running through aborts so a held fft_done never re-arms
    always_ff @(posedge clk)
        done_q <= !rst && fft_done;

    always_ff @(posedge clk) begin
        if (rst) rd_bank <= 1'b0;
        else if (state == IDLE && arm && !fft_start) rd_bank <= res_bank;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            case (state)
                IDLE:  if (arm) state <= READ;
                READ:  if (rd_en) begin
                    addr <= addr + 1'b1;
                    if (addr == LEVEL'(N - 1)) state <= DRAIN;
                end
                DRAIN: if (pop && m_last) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // credits: reads issued but not yet popped, covering pipe, stage and FIFO
    always_ff @(posedge clk)
        outst <= kill ? '0 : outst + CW'(rd_en) - CW'(pop);

    always_ff @(posedge clk) begin
        vp[0] <= !kill && rd_en;
        ip[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) begin
            vp[i] <= !kill && vp[i-1];
            ip[i] <= ip[i-1];
        end
    end

`ifdef FFT_RESULT_MAG_EN
    logic signed [2*DW-1:0] sre, sim, sq_re, sq_im;
    logic                   sv;
    assign sre   = (2*DW)'($signed(rd_re));
    assign sim   = (2*DW)'($signed(rd_im));
    assign sq_re = sre * sre;
    assign sq_im = sim * sim;
`endif

    always_comb begin
        rb.re    = rd_re;
        rb.im    = rd_im;
        rb.index = ip[RD_LAT-1];
        rb.last  = ip[RD_LAT-1] == LEVEL'(N - 1);
`ifdef FFT_RESULT_MAG_EN
        rb.mag   = {1'b0, sq_re} + {1'b0, sq_im};
`endif
    end

`ifdef FFT_RESULT_MAG_EN
    always_ff @(posedge clk) begin
        sv <= !kill && vp[RD_LAT-1];
        pb <= rb;
    end
    assign push = sv;
`else
    assign push = vp[RD_LAT-1];
    assign pb   = rb;
`endif

    fft_out_fifo #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fft_start),
        .push  (push),
        .din   (pb),
        .pop   (pop),
        .dout  (head),
        .valid (f_valid)
    );

    assign m_valid = f_valid;
    assign m_re    = f_valid ? head.re : '0;
    assign m_im    = f_valid ? head.im : '0;
    assign m_index = f_valid ? head.index : '0;
    assign m_last  = f_valid && head.last;
`ifdef FFT_RESULT_MAG_EN
    assign m_mag   = f_valid ? head.mag : '0;
`endif
endmodule
